// File: rtl/bus_master.sv
// rtl/bus_master.sv - front-panel bus master that borrows the halted 6502 bus for single RAM accesses.
// Phase timing: GRANT 4, SETUP 3, STROBE 12, HOLD 3, LINGER up to 8, RELEASE 4 clk cycles.
module bus_master (
    input  logic        clk,
    input  logic        rst_p,
    input  logic        cpu_stopped,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic [7:0]  din,
    output logic        busy,
    output logic        ack,
    output logic        rej,
    output logic [7:0]  rdata,
    output logic        bus_drive_n,
    output logic [15:0] a_out,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        rw_out,
    output logic        ram_cs_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_LINGER,
        S_RELEASE
    } state_e;

    localparam logic [3:0] GRANT_LAST   = 4'd3;
    localparam logic [3:0] SETUP_LAST   = 4'd2;
    localparam logic [3:0] STROBE_LAST  = 4'd11;
    localparam logic [3:0] HOLD_LAST    = 4'd2;
    localparam logic [3:0] LINGER_LAST  = 4'd7;
    localparam logic [3:0] RELEASE_LAST = 4'd3;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        accept;
    logic        xfer_d;

    logic        busy_q;
    logic        ack_q;
    logic        rej_q;
    logic [7:0]  rdata_q;
    logic        bus_drive_n_q;
    logic [15:0] a_out_q;
    logic [7:0]  d_out_q;
    logic        d_oe_q;
    logic        rw_out_q;
    logic        ram_cs_n_q;

    always_comb begin
        accept  = req & ~busy_q & cpu_stopped &
                  ((state_q == S_IDLE) | (state_q == S_LINGER));
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        addr_d  = accept ? addr  : addr_q;
        we_d    = accept ? we    : we_q;
        wdata_d = accept ? wdata : wdata_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (cnt_q == GRANT_LAST) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                // A stopped CPU that has resumed must get its bus back at once.
                if (cnt_q == HOLD_LAST) begin
                    state_d = cpu_stopped ? S_LINGER : S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_LINGER: begin
                if (accept) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end else if (!cpu_stopped || cnt_q == LINGER_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_RELEASE: begin
                if (cnt_q == RELEASE_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        xfer_d = (state_d == S_SETUP) | (state_d == S_STROBE) | (state_d == S_HOLD);
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            busy_q        <= 1'b0;
            ack_q         <= 1'b0;
            rej_q         <= 1'b0;
            rdata_q       <= '0;
            bus_drive_n_q <= 1'b1;
            a_out_q       <= '0;
            d_out_q       <= '0;
            d_oe_q        <= 1'b0;
            rw_out_q      <= 1'b1;
            ram_cs_n_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            busy_q        <= !((state_d == S_IDLE) || (state_d == S_LINGER));
            ack_q         <= (state_d == S_HOLD) && (cnt_d == HOLD_LAST);
            rej_q         <= req & ~busy_q & ~cpu_stopped;
            if (state_q == S_STROBE && cnt_q == STROBE_LAST && !we_q) begin
                rdata_q <= din;
            end
            bus_drive_n_q <= (state_d == S_IDLE) || (state_d == S_RELEASE);
            a_out_q       <= ((state_d == S_IDLE) || (state_d == S_RELEASE)) ? 16'h0000 : addr_d;
            d_oe_q        <= xfer_d & we_d;
            d_out_q       <= (xfer_d & we_d) ? wdata_d : 8'h00;
            rw_out_q      <= xfer_d ? ~we_d : 1'b1;
            ram_cs_n_q    <= (state_d != S_STROBE);
        end
    end

    assign busy        = busy_q;
    assign ack         = ack_q;
    assign rej         = rej_q;
    assign rdata       = rdata_q;
    assign bus_drive_n = bus_drive_n_q;
    assign a_out       = a_out_q;
    assign d_out       = d_out_q;
    assign d_oe        = d_oe_q;
    assign rw_out      = rw_out_q;
    assign ram_cs_n    = ram_cs_n_q;

endmodule
